// File: rtl/map_pkg.sv
// Shared constants and FSM encoding for the maze-map painter.
// Used by map_drawer and map_tile_cnt.
package map_pkg;

  localparam int MAP_W     = 27;
  localparam int MAP_H     = 24;
  localparam int TILE      = 4;
  localparam int TILE_LOG2 = $clog2(TILE);
  localparam int X_ORG     = 26;
  localparam int Y_ORG     = 12;

  localparam logic [2:0] WALL_COLOUR = 3'b001;
  localparam logic [2:0] BG_COLOUR   = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_DRAW   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/map_tile_cnt.sv
// Tile coordinate counter: ty runs fastest, tx steps when ty wraps (column-major sweep).
// Clears back to tile (0,0) after the last tile so the next sweep starts clean.
module map_tile_cnt
  import map_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       advance,
  output logic [7:0] tx,
  output logic [6:0] ty,
  output logic       last_tile
);

  assign last_tile = (tx == 8'(MAP_W - 1)) && (ty == 7'(MAP_H - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx <= '0;
      ty <= '0;
    end else if (advance) begin
      if (last_tile) begin
        tx <= '0;
        ty <= '0;
      end else if (ty == 7'(MAP_H - 1)) begin
        ty <= '0;
        tx <= tx + 8'd1;
      end else begin
        ty <= ty + 7'd1;
      end
    end
  end

endmodule

// File: rtl/map_drawer.sv
// Sweeps every map tile, looks up its wall bit and paints it as a TILE x TILE pixel block.
// Optional MAP_DRAW_SKIP_EMPTY_EN: empty tiles are skipped so only walls are painted.
module map_drawer
  import map_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] map_x,
  output logic [6:0] map_y,
  input  logic       map_q,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot
);

  state_t state, next_state;

  logic [7:0]           tx;
  logic [6:0]           ty;
  logic                 last_tile;
  logic                 advance;
  logic                 wall_r;
  logic [TILE_LOG2-1:0] px, py;
  logic                 tile_end;

  map_tile_cnt u_tile_cnt (
    .clock     (clock),
    .resetn    (resetn),
    .advance   (advance),
    .tx        (tx),
    .ty        (ty),
    .last_tile (last_tile)
  );

  assign tile_end = (&px) && (&py);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    advance    = 1'b0;
    case (state)
      S_IDLE:   if (start) next_state = S_LOOKUP;
      S_LOOKUP: begin
`ifdef MAP_DRAW_SKIP_EMPTY_EN
        if (!map_q) begin
          advance    = 1'b1;
          next_state = last_tile ? S_DONE : S_LOOKUP;
        end else begin
          next_state = S_DRAW;
        end
`else
        next_state = S_DRAW;
`endif
      end
      S_DRAW: begin
        if (tile_end) begin
          advance    = 1'b1;
          next_state = last_tile ? S_DONE : S_LOOKUP;
        end
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    map_x = tx;
    map_y = ty;
  end

  // px is the inner pixel loop; both wrap to 0 together at the end of each tile
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px     <= '0;
      py     <= '0;
      wall_r <= 1'b0;
    end else begin
      if (state == S_LOOKUP) wall_r <= map_q;
      if (state == S_DRAW) begin
        px <= px + 1'b1;
        if (&px) py <= py + 1'b1;
      end
    end
  end

  // Pixel outputs are registered so the VGA port never sees combinational glitches
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      plot   <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      colour <= '0;
    end else if (state == S_DRAW) begin
      plot   <= 1'b1;
      x_out  <= 8'(X_ORG) + 8'(tx << TILE_LOG2) + 8'(px);
      y_out  <= 7'(Y_ORG) + 7'(ty << TILE_LOG2) + 7'(py);
      colour <= wall_r ? WALL_COLOUR : BG_COLOUR;
    end else begin
      plot   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_map_drawer.sv
// Randomised-map bench for map_drawer: a behavioural sweep model fills a pixel queue,
// and a monitor pops and checks every plotted pixel.
module tb_map_drawer;

  localparam int W = 27;
  localparam int H = 24;
  localparam int T = 4;
  localparam int XO = 26;
  localparam int YO = 12;

  typedef struct {
    int x;
    int y;
    int c;
  } pixel_t;

  logic       clock;
  logic       resetn;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] map_x;
  logic [6:0] map_y;
  logic       map_q;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;

  bit     mapArr[W][H];
  pixel_t expQ[$];
  int     total = 0;
  int     bad = 0;
  int     plotCount = 0;
  int     doneCount = 0;

  map_drawer dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .map_x  (map_x),
    .map_y  (map_y),
    .map_q  (map_q),
    .x_out  (x_out),
    .y_out  (y_out),
    .colour (colour),
    .plot   (plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    map_q = 1'b0;
    if (int'(map_x) < W && int'(map_y) < H) map_q = mapArr[map_x][map_y];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every plotted pixel must be the next one the model predicted
  always @(negedge clock) begin
    pixel_t e;
    if (resetn) begin
      if (done) doneCount++;
      if (plot) begin
        plotCount++;
        if (expQ.size() == 0) begin
          checkOutput("plot_unexpected", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("pix_x", int'(x_out), e.x);
          checkOutput("pix_y", int'(y_out), e.y);
          checkOutput("pix_colour", int'(colour), e.c);
        end
      end
    end
  end

  task automatic randomizeMap();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        mapArr[x][y] = ($urandom_range(0, 2) == 0);
    mapArr[1][0] = 1'b1;
    mapArr[0][0] = 1'b0;
    mapArr[0][9] = 1'b1;
  endtask

  // Reference sweep: tiles column-major, pixels row by row inside a tile
  task automatic buildExpected(output int nPlots);
    bit skip;
`ifdef MAP_DRAW_SKIP_EMPTY_EN
    skip = 1'b1;
`else
    skip = 1'b0;
`endif
    nPlots = 0;
    for (int tx = 0; tx < W; tx++)
      for (int ty = 0; ty < H; ty++) begin
        if (skip && !mapArr[tx][ty]) continue;
        for (int py = 0; py < T; py++)
          for (int px = 0; px < T; px++) begin
            pixel_t p;
            p.x = XO + tx * T + px;
            p.y = YO + ty * T + py;
            p.c = mapArr[tx][ty] ? 1 : 0;
            expQ.push_back(p);
            nPlots++;
          end
      end
  endtask

  task automatic applyStimulus(input bit pulses);
    int  cyc, expCyc, expPlots, plots0, done0, firstPlot;
    bit  busyOk, gotDone, quietOk;
    randomizeMap();
    buildExpected(expPlots);
`ifdef MAP_DRAW_SKIP_EMPTY_EN
    expCyc = W * H + expPlots + 1;
`else
    expCyc = W * H * (1 + T * T) + 1;
`endif
    plots0 = plotCount;
    done0 = doneCount;
    firstPlot = 0;
    busyOk = 1'b1;
    gotDone = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!gotDone && cyc < 20000) begin
      if (!busy) busyOk = 1'b0;
      if (plot && firstPlot == 0) firstPlot = cyc;
      if (done) begin
        gotDone = 1'b1;
      end else begin
        start = (pulses && cyc == 100);
        @(negedge clock);
        cyc++;
      end
    end
    checkOutput("done_seen", int'(gotDone), 1);
    checkOutput("done_cycle", cyc, expCyc);
    checkOutput("busy_during_sweep", int'(busyOk), 1);
`ifndef MAP_DRAW_SKIP_EMPTY_EN
    checkOutput("first_plot_cycle", firstPlot, 3);
`endif
    if (pulses) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    quietOk = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (plot || busy || done) quietOk = 1'b0;
    end
    checkOutput("idle_after_done", int'(quietOk), 1);
    checkOutput("plot_count", plotCount - plots0, expPlots);
    checkOutput("done_pulses", doneCount - done0, 1);
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_plot"}, int'(plot), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_xy"}, int'(x_out) + int'(y_out), 0);
    checkOutput({tag, "_colour"}, int'(colour), 0);
  endtask

  // Interrupt a sweep inside tile (10,5)'s DRAW phase with an asynchronous reset
  task automatic resetMidSweep();
    int dummy;
    bit quietOk;
    randomizeMap();
    buildExpected(dummy);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat ((10 * H + 5) * (1 + T * T) + 5) @(negedge clock);
    #2 resetn = 1'b0;
    #1 checkResetState("midreset");
    expQ.delete();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    start = 1'b0;
    quietOk = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (plot || busy) quietOk = 1'b0;
    end
    checkOutput("no_plot_after_reset", int'(quietOk), 1);
  endtask

  initial begin
    bit quietOk;
    resetn = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    checkResetState("reset");
    resetn = 1'b1;
    quietOk = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (plot || busy || done) quietOk = 1'b0;
    end
    checkOutput("idle_before_start", int'(quietOk), 1);
    $display("[TB] sweep with start pulses during DRAW and DONE");
    applyStimulus(1'b1);
    $display("[TB] reset in the middle of a sweep");
    resetMidSweep();
    $display("[TB] full sweep after reset");
    applyStimulus(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
